// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the load/store unit: request/grant/response handshake
// plus the address, byte-enable and data buses.
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: memory handshake, byte lanes, load extension.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  lsu_ctrl_if.master  mem
);

  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h15;
  localparam logic [5:0] ALU_SH  = 6'h16;
  localparam logic [5:0] ALU_SW  = 6'h17;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state_q, state_d;
  size_t       size_in, size_q;
  logic        is_mem, is_store, is_uns;
  logic        store_q, uns_q;
  logic [1:0]  off_d, off_q;
  logic [3:0]  be_d, be_q;
  logic [31:0] wdata_d, wdata_q;
  logic [31:0] maddr_q, rdata_q, ext_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        accept, capture;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis_now, mis_q;
`endif

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    is_uns   = 1'b0;
    size_in  = SZ_W;
    case (alucode)
      ALU_LB:  size_in = SZ_B;
      ALU_LH:  size_in = SZ_H;
      ALU_LW:  size_in = SZ_W;
      ALU_LBU: begin size_in = SZ_B; is_uns = 1'b1; end
      ALU_LHU: begin size_in = SZ_H; is_uns = 1'b1; end
      ALU_SB:  begin size_in = SZ_B; is_store = 1'b1; end
      ALU_SH:  begin size_in = SZ_H; is_store = 1'b1; end
      ALU_SW:  is_store = 1'b1;
      default: is_mem = 1'b0;
    endcase
  end

  // Without the trap, offending low address bits snap to the natural boundary
  // before lane selection, so the access proceeds as an aligned one.
  always_comb begin
    off_d   = addr[1:0];
    be_d    = 4'hF;
    wdata_d = wdata;
    case (size_in)
      SZ_B: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      SZ_H: begin
`ifndef LSU_MISALIGN_TRAP_EN
        off_d[0] = 1'b0;
`endif
        be_d    = 4'b0011 << {off_d[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
`ifndef LSU_MISALIGN_TRAP_EN
        off_d = 2'b00;
`endif
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = ((size_in == SZ_H) && addr[0]) ||
                   ((size_in == SZ_W) && (addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (start && is_mem) begin
        accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        state_d = mis_now ? DONE : REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: if (mem.mem_gnt) begin
        if (store_q) begin
          state_d = DONE;
        end else if (mem.mem_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (mem.mem_rvalid) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    ext_data = mem.mem_rdata;
    case (off_q)
      2'd0: byte_sel = mem.mem_rdata[7:0];
      2'd1: byte_sel = mem.mem_rdata[15:8];
      2'd2: byte_sel = mem.mem_rdata[23:16];
      default: byte_sel = mem.mem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (size_q)
      SZ_B: ext_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H: ext_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= size_in;
        store_q <= is_store;
        uns_q   <= is_uns;
        off_q   <= off_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        maddr_q <= {addr[31:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q   <= mis_now;
`endif
      end
      if (capture) rdata_q <= ext_data;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign rdata         = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned    = (state_q == DONE) && mis_q;
`else
  assign misaligned    = 1'b0;
`endif
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = (state_q == REQ) && store_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expectations queued at start, compared at done.
module tb_lsu_ctrl;

  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h15;
  localparam logic [5:0] ALU_SH  = 6'h16;
  localparam logic [5:0] ALU_SW  = 6'h17;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, busy, done, misaligned;
  logic [5:0]  alucode;
  logic [31:0] addr, wdata, rdata;
  lsu_ctrl_if  mif ();

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .alucode(alucode), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .mem(mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t model(logic [5:0] op, logic [31:0] a_in, logic [31:0] d,
                                 logic [31:0] w, logic [31:0] prev);
    exp_t e;
    logic [31:0] a;
    logic isb, ish, isw, ld, sx, bad;
    logic [7:0]  b;
    logic [15:0] h;
    a   = a_in;
    isb = op inside {ALU_LB, ALU_LBU, ALU_SB};
    ish = op inside {ALU_LH, ALU_LHU, ALU_SH};
    isw = op inside {ALU_LW, ALU_SW};
    ld  = op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    sx  = op inside {ALU_LB, ALU_LH};
    bad = (ish && a[0]) || (isw && (a[1:0] != 2'b00));
    e.mis = TRAP && bad;
    e.req = !e.mis;
    if (!TRAP && ish) a[0] = 1'b0;
    if (!TRAP && isw) a[1:0] = 2'b00;
    e.we     = !ld;
    e.maddr  = a & 32'hFFFF_FFFC;
    e.be     = isw ? 4'hF : ish ? (a[1] ? 4'hC : 4'h3) : (4'h1 << a[1:0]);
    e.mwdata = isw ? d : ish ? {d[15:0], d[15:0]} : {4{d[7:0]}};
    b = 8'(w >> (8 * a[1:0]));
    h = a[1] ? w[31:16] : w[15:0];
    e.rdata = prev;
    if (ld && e.req) begin
      if (isb)      e.rdata = sx ? {{24{b[7]}}, b} : {24'h0, b};
      else if (ish) e.rdata = sx ? {{16{h[15]}}, h} : {16'h0, h};
      else          e.rdata = w;
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction; memory side answers after gnt_dly REQ cycles and
  // rv_dly cycles after grant; a stray start is injected at REQ cycle 'poke'.
  task automatic txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] w, input int gnt_dly, input int rv_dly,
                     input int poke, output int lat);
    exp_t e;
    int rc, wc;
    bit granted, seen;
    e = model(op, a, d, w, last_rdata);
    exp_q.push_back(e);
    start = 1'b1; alucode = op; addr = a; wdata = d;
    cyc();
    start = 1'b0;
    lat = 1; rc = 0; wc = 0; granted = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (!granted) begin
          checks++;
          if (mif.mem_req !== e.req) begin errors++; $display("FAIL req: got %b want %b", mif.mem_req, e.req); end
          if (mif.mem_req) begin
            checks++;
            if ({mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata} !== {e.we, e.maddr, e.be, e.mwdata}) begin
              errors++;
              $display("FAIL mem_bus: got we=%b a=%h be=%h d=%h want we=%b a=%h be=%h d=%h",
                       mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata, e.we, e.maddr, e.be, e.mwdata);
            end
            if (rc == poke) begin start = 1'b1; alucode = ALU_SW; addr = 32'h300; end
            if (rc == gnt_dly) begin
              mif.mem_gnt = 1'b1; granted = 1;
              if (!e.we && rv_dly == 0) begin mif.mem_rvalid = 1'b1; mif.mem_rdata = w; end
            end
            rc++;
          end
        end else begin
          checks++;
          if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", mif.mem_req); end
          wc++;
          if (!e.we && wc == rv_dly) begin mif.mem_rvalid = 1'b1; mif.mem_rdata = w; end
        end
        cyc();
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom; start = 1'b0;
        lat++;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout: got no done want done"); end
    checks++;
    if ({busy, mif.mem_req} !== 2'b10) begin errors++; $display("FAIL done_state: got busy/req=%b%b want 10", busy, mif.mem_req); end
    checks++;
    if (rdata !== e.rdata) begin errors++; $display("FAIL rdata: got %h want %h", rdata, e.rdata); end
    checks++;
    if (misaligned !== e.mis) begin errors++; $display("FAIL misaligned: got %b want %b", misaligned, e.mis); end
    last_rdata = e.rdata;
    cyc();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_pulse: got done/busy=%b%b want 00", done, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alucode = '0; addr = '0; wdata = '0;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    last_rdata = '0;
    cyc(); cyc();
    checks++;
    if ({busy, done, rdata, misaligned, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b rdata=%h mis=%b req=%b we=%b a=%h be=%h d=%h want all 0",
               busy, done, rdata, misaligned, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_store();
    int lat;
    txn(ALU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, -1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata_kept: got %h want 0", rdata); end
    txn(ALU_SB, 32'h103, 32'h000000A5, 32'h0, 0, 0, -1, lat);
    checks++;
    if ({mif.mem_addr, mif.mem_be, mif.mem_wdata} !== {32'h100, 4'b1000, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_lanes: got a=%h be=%b d=%h want a=00000100 be=1000 d=a5a5a5a5", mif.mem_addr, mif.mem_be, mif.mem_wdata);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sb_min_latency: got %0d want 2", lat); end
    txn(ALU_SH, 32'h102, 32'h1234BEEF, 32'h0, 2, 0, -1, lat);
  endtask

  task automatic test_load();
    int lat;
    txn(ALU_LB, 32'h102, 32'h0, 32'h12F45678, 0, 2, -1, lat);
    checks++;
    if (rdata !== 32'hFFFFFFF4) begin errors++; $display("FAIL lb: got %h want fffffff4", rdata); end
    txn(ALU_LBU, 32'h102, 32'h0, 32'h12F45678, 0, 2, -1, lat);
    checks++;
    if (rdata !== 32'h000000F4) begin errors++; $display("FAIL lbu: got %h want 000000f4", rdata); end
    txn(ALU_LHU, 32'h102, 32'h0, 32'h12F45678, 1, 1, -1, lat);
    checks++;
    if (rdata !== 32'h000012F4) begin errors++; $display("FAIL lhu: got %h want 000012f4", rdata); end
    txn(ALU_LH, 32'h100, 32'h0, 32'h00008001, 0, 1, -1, lat);
    checks++;
    if (rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %h want ffff8001", rdata); end
    txn(ALU_LW, 32'h104, 32'h0, 32'h89ABCDEF, 0, 0, -1, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_min_latency: got %0d want 2", lat); end
    txn(ALU_LB, 32'h107, 32'h0, 32'h7F000000, 0, 0, -1, lat);
    checks++;
    if (rdata !== 32'h0000007F) begin errors++; $display("FAIL lb_lane3: got %h want 0000007f", rdata); end
  endtask

  task automatic test_misaligned();
    int lat, want_lat;
    logic [31:0] want_rd;
    want_rd  = TRAP ? last_rdata : 32'hCAFEF00D;
    want_lat = TRAP ? 1 : 3;
    txn(ALU_LW, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1, -1, lat);
    checks++;
    if (lat !== want_lat) begin errors++; $display("FAIL lw_mis_latency: got %0d want %0d", lat, want_lat); end
    checks++;
    if (rdata !== want_rd) begin errors++; $display("FAIL lw_mis_rdata: got %h want %h", rdata, want_rd); end
    txn(ALU_SH, 32'h101, 32'h0000ABCD, 32'h0, 0, 0, -1, lat);
    txn(ALU_LH, 32'h103, 32'h0, 32'h80017FFF, 0, 0, -1, lat);
  endtask

  task automatic test_stall();
    int lat;
    txn(ALU_SW, 32'h40, 32'h11223344, 32'h0, 5, 0, 2, lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", lat); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({done, busy, mif.mem_req} !== 3'b000) begin
        errors++; $display("FAIL stall_no_second: got done/busy/req=%b%b%b want 000", done, busy, mif.mem_req);
      end
      cyc();
    end
  endtask

  task automatic test_ignored_op();
    start = 1'b1; alucode = 6'h05; addr = 32'h500;
    cyc();
    start = 1'b0;
    mif.mem_gnt = 1'b1; mif.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({done, busy, mif.mem_req, rdata} !== {3'b000, last_rdata}) begin
        errors++; $display("FAIL ignored_op: got done/busy/req=%b%b%b rdata=%h want 000 %h", done, busy, mif.mem_req, rdata, last_rdata);
      end
      cyc();
    end
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    txn(ALU_SB, 32'h20, 32'h0000005A, 32'h0, 0, 0, -1, lat1);
    txn(ALU_LW, 32'h24, 32'h0, 32'h0BADF00D, 0, 0, -1, lat2);
    checks++;
    if ({lat1, lat2} !== {32'd2, 32'd2}) begin errors++; $display("FAIL b2b_latency: got %0d/%0d want 2/2", lat1, lat2); end
  endtask

  task automatic test_reset_wait();
    int lat;
    start = 1'b1; alucode = ALU_LW; addr = 32'h200;
    cyc();
    start = 1'b0;
    mif.mem_gnt = 1'b1;
    cyc();
    mif.mem_gnt = 1'b0;
    checks++;
    if ({busy, mif.mem_req} !== 2'b10) begin errors++; $display("FAIL wait_state: got busy/req=%b%b want 10", busy, mif.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, rdata, misaligned, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_abort: got busy=%b done=%b rdata=%h req=%b a=%h want all 0", busy, done, rdata, mif.mem_req, mif.mem_addr);
    end
    cyc();
    rst = 1'b0;
    last_rdata = '0;
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h55AA55AA;
    cyc();
    mif.mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({done, busy, rdata} !== 34'h0) begin errors++; $display("FAIL late_rvalid: got done/busy=%b%b rdata=%h want 00 0", done, busy, rdata); end
      cyc();
    end
    txn(ALU_LW, 32'h204, 32'h0, 32'h13572468, 0, 0, -1, lat);
    checks++;
    if (rdata !== 32'h13572468) begin errors++; $display("FAIL post_reset_load: got %h want 13572468", rdata); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_stall();
    test_ignored_op();
    test_back_to_back();
    test_reset_wait();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the execute/memory boundary of the CPU core. Consumes the memory-class `alucode` plus the ALU-computed effective address, runs a request/grant/response handshake with the data memory port, and returns extended load data. It generates byte-lane enables for stores and performs sign or zero extension for loads. It also flags misaligned accesses.

## Interface
- No parameters; widths fixed at 32-bit address/data, 4 byte lanes.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request strobe from execute stage; sampled only in IDLE
- `alucode`  in  6  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` (define.vh encodings)
- `addr`  in  32  effective address (ALU result)
- `wdata`  in  32  store source (rs2)
- `busy`  out  1  high from cycle after accepted `start` until `done` cycle inclusive
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  32  extended load result, valid with `done`, held until next load completes
- `misaligned`  out  1  pulses with `done` when access was misaligned
- `mem_req`  out  1  memory request, held until `mem_gnt`
- `mem_we`  out  1  1 = store
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  load data valid this cycle
- `mem_rdata`  in  32  load data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `start` with memory-class `alucode` latches alucode, addr, wdata -> REQ. `start` with any other alucode is ignored (stay IDLE, no pulse).
- REQ: `mem_req`=1, all `mem_*` outputs stable. On `mem_gnt`: store -> DONE; load with `mem_rvalid` same cycle -> capture data, DONE; load otherwise -> WAIT.
- WAIT: `mem_req`=0; on `mem_rvalid` capture extended data -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- Byte enables: SB `4'b0001<<addr[1:0]`; SH `4'b0011<<{addr[1],1'b0}`; SW `4'b1111`; loads use the same masks per size.
- Store data: SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- Load extraction: byte lane `addr[1:0]`, halfword lane `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`!=0. Byte never misaligned.
- `mem_rvalid`/`mem_gnt` outside REQ/WAIT are ignored.

## Timing
- Reset values: all outputs 0; state IDLE. Reset mid-transaction aborts immediately; a late `mem_rvalid` after reset is dropped.
- Start in cycle 0 -> `mem_req` high in cycle 1 (registered).
- Store with gnt in cycle k -> `done` in cycle k+1. Minimum store latency: `start` to `done` is 2 cycles.
- Load with rvalid in cycle k -> `done` and new `rdata` in cycle k+1. Minimum load latency (gnt+rvalid together) is 2 cycles.
- Back-to-back: a new `start` is accepted in the cycle after `done` (IDLE). `start` while busy is ignored, never queued.
- `rdata` unchanged by stores or by misaligned aborts.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access issues no memory request. REQ is skipped: IDLE -> DONE, giving `done`+`misaligned` in the cycle after `start`, with `busy` high for that cycle.
- Undefined: `misaligned` tied 0; the offending low address bits are forced to the natural boundary (halfword `addr[0]`=0, word `addr[1:0]`=0) and the access proceeds normally.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, gnt one cycle after req -> mem_addr 0x100, be 4'hF, wdata 0xDEADBEEF, done 3 cycles after start, rdata unchanged.
- SB addr 0x103 wdata 0x000000A5 -> be 4'b1000, mem_wdata 0xA5A5A5A5, mem_addr 0x100.
- LB addr 0x102, mem_rdata 0x12F45678, rvalid 2 cycles after gnt -> rdata 0xFFFFFFF4; same with LBU -> 0x000000F4; LHU addr 0x102 -> 0x000012F4.
- LW addr 0x102: with `LSU_MISALIGN_TRAP_EN` -> no mem_req, done+misaligned next cycle; without it -> mem_addr 0x100, full word returned, misaligned 0.
- Stall: gnt withheld 5 cycles -> mem_req and mem_* stable throughout, a second start during busy is ignored, exactly one done.
- Assert rst while in WAIT, then pulse rvalid -> all outputs 0, no done, next start executes normally.
